// File: rtl/recorder_pkg.sv
// Shared voice-recorder definitions: bus widths, memory bound and FSM encodings.
package recorder_pkg;

    localparam int unsigned          REC_ADDR_W   = 17;
    localparam int unsigned          REC_DATA_W   = 8;
    localparam logic [REC_ADDR_W-1:0] REC_MAX_ADDR = 17'h1FFFF;

    // Record-path deserializer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } des_state_t;

    // Top-level controller modes.
    typedef enum logic [1:0] {
        STANDBY = 2'd0,
        RECORD  = 2'd1,
        PLAY    = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/mic_clock_gen.sv
// Microphone bit-clock divider: micClock high for the first half of each
// CLK_DIV-cycle period, sampleTick on the last count of the period.
module mic_clock_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic micClock,
    output logic sampleTick
);

    localparam int unsigned   CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] div_cnt;

    // Divider counts 0..CLK_DIV-1 while running, held at zero otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (!run || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Decode clock phase and sample point from the registered count.
    always_comb begin
        micClock   = run && (div_cnt < HALF);
        sampleTick = run && (div_cnt == LAST);
    end

endmodule

// File: rtl/audio_deserializer.sv
// Record-path front end: synchronizes the microphone bit stream, packs
// DATA_W bits MSB-first and emits each word with its clip-memory address.
module audio_deserializer
    import recorder_pkg::*;
#(
    parameter int unsigned         CLK_DIV  = 4,
    parameter int unsigned         DATA_W   = REC_DATA_W,
    parameter int unsigned         ADDR_W   = REC_ADDR_W,
    parameter logic [ADDR_W-1:0]   MAX_ADDR = ADDR_W'(REC_MAX_ADDR)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enableDes,
    input  logic [ADDR_W-1:0] startAddress,
    input  logic              micData,
    output logic              micClock,
    output logic [DATA_W-1:0] dataOut,
    output logic [ADDR_W-1:0] addrOut,
    output logic              wordValid,
    output logic              full
);

    localparam int unsigned   BW       = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    des_state_t        state, state_nxt;
    logic              sync1, sync2;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shifted;
    logic [BW-1:0]     bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic              run;
    logic              sample_tick;
    logic              word_done;

    mic_clock_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_mic_clock_gen (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .micClock   (micClock),
        .sampleTick (sample_tick)
    );

    // Capture side conditions; a disable in the tick cycle discards that bit.
    always_comb begin
        run       = (state == CAPTURE);
        shifted   = {shift[DATA_W-2:0], sync2};
        word_done = sample_tick && enableDes && (bit_cnt == LAST_BIT);
    end

    // Two-flop synchronizer for the asynchronous microphone data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= micData;
            sync2 <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enableDes) state_nxt = CAPTURE;
            CAPTURE: begin
                if (!enableDes) begin
                    state_nxt = IDLE;
                end else if (word_done && addr == MAX_ADDR) begin
                    state_nxt = FULL;
                end
            end
            FULL:    if (!enableDes) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift/pack datapath, address counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            dataOut   <= '0;
            addrOut   <= '0;
            wordValid <= 1'b0;
            full      <= 1'b0;
        end else begin
            wordValid <= 1'b0;
            full      <= (state_nxt == FULL);
            if (state == IDLE && enableDes) begin
                addr    <= startAddress;
                shift   <= '0;
                bit_cnt <= '0;
            end else if (run && enableDes && sample_tick) begin
                shift <= shifted;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    dataOut   <= shifted;
                    addrOut   <= addr;
                    wordValid <= 1'b1;
                    if (addr != MAX_ADDR) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_deserializer.sv
// Bench for audio_deserializer: table of capture scenarios plus randomized
// runs, checked cycle by cycle against a timeline model of the recorder.
module tb_audio_deserializer;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 17;
    localparam int          PERIOD   = DATA_W * CLK_DIV;
    localparam logic [16:0] MAX_ADDR = 17'h1FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enableDes = 1'b0;
    logic [16:0] startAddress = '0;
    logic        micData = 1'b0;
    logic        micClock;
    logic [7:0]  dataOut;
    logic [16:0] addrOut;
    logic        wordValid;
    logic        full;

    audio_deserializer #(
        .CLK_DIV  (CLK_DIV),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enableDes    (enableDes),
        .startAddress (startAddress),
        .micData      (micData),
        .micClock     (micClock),
        .dataOut      (dataOut),
        .addrOut      (addrOut),
        .wordValid    (wordValid),
        .full         (full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [16:0] start;
        logic [15:0] pat;
        int          npat;
        int          drop_at;
        bit          chk_end;
        int          exp_n;
        logic        exp_full;
        logic [7:0]  exp_word;
        logic [16:0] exp_addr;
    } scen_t;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  exp_data = '0;
    logic [16:0] exp_addr = '0;
    logic        hist [0:1023];
    int          obs_n;
    logic        obs_full;
    scen_t       tbl [8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic mc, input logic wv, input logic fl);
        chk({tag, " micClock"},  32'(micClock),  32'(mc));
        chk({tag, " wordValid"}, 32'(wordValid), 32'(wv));
        chk({tag, " full"},      32'(full),      32'(fl));
        chk({tag, " dataOut"},   32'(dataOut),   32'(exp_data));
        chk({tag, " addrOut"},   32'(addrOut),   32'(exp_addr));
    endtask

    // Word n gathers ticks n*DATA_W+1 .. n*DATA_W+DATA_W, MSB first; tick k
    // falls at cycle k*CLK_DIV-1 and sees micData from two cycles earlier.
    function automatic logic [7:0] model_word(input int n);
        logic [7:0] w = '0;
        for (int b = 1; b <= DATA_W; b++) begin
            w = {w[6:0], hist[(n * DATA_W + b) * CLK_DIV - 3]};
        end
        return w;
    endfunction

    task automatic run_capture(input int idx, input scen_t s);
        int nwords;
        nwords   = int'(MAX_ADDR) - int'(s.start) + 1;
        obs_n    = 0;
        obs_full = 1'b0;
        startAddress = s.start;
        enableDes    = 1'b1;
        step();
        for (int c = 0; c <= s.drop_at + 1; c++) begin
            bit    act;
            bit    strobe;
            bit    mc;
            logic  md;
            string tag;
            tag    = $sformatf("s%0d c%0d", idx, c);
            act    = (c <= s.drop_at);
            strobe = (c > 0) && (c % PERIOD == 0) && (c / PERIOD <= nwords) && (c - 1 < s.drop_at);
            mc     = act && (c < nwords * PERIOD) && ((c % CLK_DIV) < CLK_DIV / 2);
            if (strobe) begin
                exp_data = model_word(c / PERIOD - 1);
                exp_addr = s.start + 17'(c / PERIOD - 1);
            end
            check_outs(tag, mc, strobe, act && (c >= nwords * PERIOD));
            if (wordValid) obs_n++;
            if (full) obs_full = 1'b1;
            if (c / int'(CLK_DIV) < s.npat) md = s.pat[s.npat - 1 - c / int'(CLK_DIV)];
            else md = 1'($urandom);
            hist[c] = md;
            micData = md;
            if (c == s.drop_at) enableDes = 1'b0;
            step();
        end
        if (s.chk_end) begin
            chk($sformatf("s%0d strobes", idx),   32'(obs_n),    32'(s.exp_n));
            chk($sformatf("s%0d full_seen", idx), 32'(obs_full), 32'(s.exp_full));
            chk($sformatf("s%0d end_data", idx),  32'(dataOut),  32'(s.exp_word));
            chk($sformatf("s%0d end_addr", idx),  32'(addrOut),  32'(s.exp_addr));
        end
    endtask

    initial begin
        scen_t r;
        // start, pattern, bits, drop_at, chk_end, strobes, full, end data, end addr
        tbl[0] = '{17'h00010, 16'h00A5,  8,  40, 1'b1, 1, 1'b0, 8'hA5, 17'h00010};
        tbl[1] = '{17'h00010, 16'hA53C, 16,  70, 1'b1, 2, 1'b0, 8'h3C, 17'h00011};
        tbl[2] = '{17'h00040, 16'h0000,  0,  21, 1'b1, 0, 1'b0, 8'h3C, 17'h00011};
        tbl[3] = '{17'h00020, 16'h005A,  8,  40, 1'b1, 1, 1'b0, 8'h5A, 17'h00020};
        tbl[4] = '{17'h1FFFE, 16'hC381, 16,  80, 1'b1, 2, 1'b1, 8'h81, 17'h1FFFF};
        tbl[5] = '{17'h1FFFF, 16'h007E,  8,  50, 1'b1, 1, 1'b1, 8'h7E, 17'h1FFFF};
        tbl[6] = '{17'h01234, 16'h0000,  0, 200, 1'b0, 6, 1'b0, 8'h00, 17'h00000};
        tbl[7] = '{17'h00030, 16'h0000,  0,  32, 1'b0, 1, 1'b0, 8'h00, 17'h00000};

        #1 reset = 1'b0;
        #1 check_outs("reset", 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_outs("in_reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_capture(i, tbl[i]);
        end

        for (int i = 0; i < 4; i++) begin
            r = '{17'h0, 16'h0, 0, 0, 1'b0, 0, 1'b0, 8'h0, 17'h0};
            if ($urandom_range(0, 1) == 0) r.start = MAX_ADDR - 17'($urandom_range(0, 3));
            else r.start = 17'($urandom);
            r.drop_at = int'($urandom_range(10, 180));
            if (r.drop_at % PERIOD == PERIOD - 1) r.drop_at++;
            run_capture(8 + i, r);
        end

        // Reset in the middle of a capture after one word has been written.
        startAddress = 17'h00050;
        enableDes    = 1'b1;
        micData      = 1'b1;
        step();
        repeat (33) step();
        chk("pre_rst micClock", 32'(micClock), 32'd1);
        chk("pre_rst dataOut",  32'(dataOut),  32'h0FF);
        chk("pre_rst addrOut",  32'(addrOut),  32'h00050);
        #2 reset = 1'b0;
        exp_data = '0;
        exp_addr = '0;
        #1 check_outs("async_rst", 1'b0, 1'b0, 1'b0);
        enableDes = 1'b0;
        step();
        check_outs("rst_hold", 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        check_outs("post_rst_idle", 1'b0, 1'b0, 1'b0);
        enableDes = 1'b1;
        step();
        check_outs("post_rst_capture", 1'b1, 1'b0, 1'b0);
        enableDes = 1'b0;
        step();
        check_outs("post_rst_exit", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
